// File: rtl/dmem_pipe_model.sv
`default_nettype none
// +--------------------------------------------------------------------------------------------+
// | dmem_pipe_model: in-order data-memory stage (request FIFO, zero-swept word array, response |
// | pipe). Optional misaligned-access flag when DMEM_ALIGN_CHK_EN is defined.       Rev 1.0     |
// +--------------------------------------------------------------------------------------------+
module dmem_pipe_model #(
  parameter int AW      = 10,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2,
  parameter int MARGIN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        rw_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic [3:0]  id_in,
  output logic [31:0] data_out,
  output logic [3:0]  id_out,
  output logic        ready_out,
  output logic        stall_out,
  output logic        init_done,
  output logic        overflow_out
`ifdef DMEM_ALIGN_CHK_EN
  ,
  output logic        err_out
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_depth     = CW'(DEPTH);
  localparam logic [CW-1:0] c_stall_thr = CW'(DEPTH - MARGIN);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e        state_q;
  logic [AW-1:0] sweep_ptr_q;
  logic          init_done_q;
  logic          stall_q;
  logic          overflow_q;

  logic          fifo_rw_q   [DEPTH];
  logic [AW+1:0] fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [3:0]    fifo_id_q   [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic [31:0]   mem_q [2**AW];

  logic [LATENCY:1] pipe_vld_q;
  logic [LATENCY:1] pipe_err_q;
  logic [31:0]      pipe_data_q [1:LATENCY];
  logic [3:0]       pipe_id_q   [1:LATENCY];

  logic          w_pop;
  logic          w_push;
  logic          w_sweep_last;
  logic          w_misalign;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_waddr;
  logic [31:0]   w_mem_wdata;
  logic          w_head_rw;
  logic [AW+1:0] w_head_addr;
  logic [31:0]   w_head_data;
  logic [3:0]    w_head_id;
  logic [31:0]   w_resp_data;
  logic          w_unused;

  assign w_head_rw   = fifo_rw_q[rd_ptr_q];
  assign w_head_addr = fifo_addr_q[rd_ptr_q];
  assign w_head_data = fifo_data_q[rd_ptr_q];
  assign w_head_id   = fifo_id_q[rd_ptr_q];

  // A slot freed by this edge's pop can take this edge's push, so a full FIFO still accepts.
  assign w_pop   = (state_q == S_RUN) && (count_q != '0);
  assign w_push  = valid_in && ((count_q != c_depth) || w_pop);
  assign count_d = count_q + CW'(w_push) - CW'(w_pop);

  assign w_sweep_last = &sweep_ptr_q;

`ifdef DMEM_ALIGN_CHK_EN
  assign w_misalign = (w_head_addr[1:0] != 2'b00);
  assign err_out    = pipe_err_q[LATENCY];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_unused = ^{addr_in[31:AW+2], w_head_addr[1:0], pipe_err_q[LATENCY]};

  assign w_mem_we    = (state_q == S_INIT) || (w_pop && w_head_rw && !w_misalign);
  assign w_mem_waddr = (state_q == S_INIT) ? sweep_ptr_q : w_head_addr[AW+1:2];
  assign w_mem_wdata = (state_q == S_INIT) ? 32'h0 : w_head_data;

  assign w_resp_data = w_head_rw  ? w_head_data :
                       w_misalign ? 32'h0 : mem_q[w_head_addr[AW+1:2]];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_rw_q[wr_ptr_q]   <= rw_in;
      fifo_addr_q[wr_ptr_q] <= addr_in[AW+1:0];
      fifo_data_q[wr_ptr_q] <= data_in;
      fifo_id_q[wr_ptr_q]   <= id_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      if (valid_in && !w_push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      sweep_ptr_q <= '0;
      init_done_q <= 1'b0;
      stall_q     <= 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          sweep_ptr_q <= sweep_ptr_q + AW'(1);
          if (w_sweep_last) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        S_RUN: ;
      endcase
      stall_q <= ((state_q == S_INIT) && !w_sweep_last) || (count_d >= c_stall_thr);
    end
  end

  // Idle stages carry zero payload so the outputs read 0 whenever ready_out is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      for (int k = 1; k <= LATENCY; k++) begin
        pipe_data_q[k] <= '0;
        pipe_id_q[k]   <= '0;
      end
    end else begin
      pipe_vld_q[1]  <= w_pop;
      pipe_err_q[1]  <= w_pop && w_misalign;
      pipe_data_q[1] <= w_pop ? w_resp_data : 32'h0;
      pipe_id_q[1]   <= w_pop ? w_head_id : 4'h0;
      for (int k = 2; k <= LATENCY; k++) begin
        pipe_vld_q[k]  <= pipe_vld_q[k-1];
        pipe_err_q[k]  <= pipe_err_q[k-1];
        pipe_data_q[k] <= pipe_data_q[k-1];
        pipe_id_q[k]   <= pipe_id_q[k-1];
      end
    end
  end

  assign ready_out    = pipe_vld_q[LATENCY];
  assign data_out     = pipe_data_q[LATENCY];
  assign id_out       = pipe_id_q[LATENCY];
  assign stall_out    = stall_q;
  assign init_done    = init_done_q;
  assign overflow_out = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_pipe_model.sv
`default_nettype none
// +--------------------------------------------------------------------------------------------+
// | tb_dmem_pipe_model: random and directed traffic against a queue/array reference model,     |
// | responses checked by a scoreboard monitor.                                        Rev 1.0   |
// +--------------------------------------------------------------------------------------------+
module tb_dmem_pipe_model;

  localparam int AW      = 10;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;
  localparam int MARGIN  = 1;
`ifdef DMEM_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        rw_in = 1'b0;
  logic [31:0] addr_in = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [3:0]  id_in = 4'h0;
  logic [31:0] data_out;
  logic [3:0]  id_out;
  logic        ready_out;
  logic        stall_out;
  logic        init_done;
  logic        overflow_out;
`ifdef DMEM_ALIGN_CHK_EN
  logic        err_out;
`endif

  dmem_pipe_model #(
    .AW(AW), .DEPTH(DEPTH), .LATENCY(LATENCY), .MARGIN(MARGIN)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .rw_in(rw_in), .addr_in(addr_in),
    .data_in(data_in), .id_in(id_in), .data_out(data_out), .id_out(id_out),
    .ready_out(ready_out), .stall_out(stall_out), .init_done(init_done),
    .overflow_out(overflow_out)
`ifdef DMEM_ALIGN_CHK_EN
    , .err_out(err_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { bit rw; logic [31:0] addr; logic [31:0] data; logic [3:0] id; } req_t;
  typedef struct { logic [3:0] id; logic [31:0] data; bit err; int due; } rsp_t;

  req_t        mq[$];
  rsp_t        sb[$];
  logic [31:0] mmem [int];
  int          init_left;
  int          edge_n;
  bit          m_ovf;
  int          vectors = 0;
  int          miscompares = 0;
  rsp_t        mon_e;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit exp_stall();
    return (init_left != 0) || (mq.size() >= DEPTH - MARGIN);
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    mmem.delete();
    init_left = 2**AW;
    edge_n    = 0;
    m_ovf     = 1'b0;
  endtask

  // One clock edge of the reference: in-order execution from a bounded queue.
  task automatic model_edge();
    bit   run_before;
    bit   mis;
    int   idx;
    req_t r;
    rsp_t s;
    run_before = (init_left == 0);
    edge_n++;
    if (!run_before) init_left--;
    if (run_before && mq.size() > 0) begin
      r = mq.pop_front();
      idx = int'(r.addr[AW+1:2]);
      mis = ALIGN && (r.addr[1:0] != 2'b00);
      s.id  = r.id;
      s.err = mis;
      s.due = edge_n + LATENCY - 1;
      if (r.rw) begin
        s.data = r.data;
        if (!mis) mmem[idx] = r.data;
      end else begin
        s.data = (mis || !mmem.exists(idx)) ? 32'h0 : mmem[idx];
      end
      sb.push_back(s);
    end
    if (valid_in) begin
      if (mq.size() < DEPTH) mq.push_back('{rw_in, addr_in, data_in, id_in});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic drive(bit v, bit rw, logic [31:0] a, logic [31:0] d, logic [3:0] id);
    valid_in = v;
    rw_in    = rw;
    addr_in  = a;
    data_in  = d;
    id_in    = id;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic wait_init();
    for (int i = 0; i < 2**AW + 8 && init_left != 0; i++) idle(1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
    check("drain_pending", 32'(sb.size()), 32'd0);
    idle(2);
  endtask

  task automatic apply_reset();
    valid_in = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_ready_now", 32'(ready_out), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom & ~((32'd1 << (AW + 2)) - 1)) | (32'($urandom_range(0, 15)) << 2);
    if (!ALIGN) a = a | 32'($urandom_range(0, 3));
    return a;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready", 32'(ready_out), 32'd0);
      check("rst_stall", 32'(stall_out), 32'd1);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_overflow", 32'(overflow_out), 32'd0);
    end else begin
      check("stall", 32'(stall_out), 32'(exp_stall()));
      check("init_done", 32'(init_done), 32'(init_left == 0));
      check("overflow", 32'(overflow_out), 32'(m_ovf));
      if (ready_out) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(ready_out), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_id", 32'(id_out), 32'(mon_e.id));
          check("rsp_data", data_out, mon_e.data);
          check("rsp_cycle", 32'(edge_n), 32'(mon_e.due));
`ifdef DMEM_ALIGN_CHK_EN
          check("rsp_err", 32'(err_out), 32'(mon_e.err));
`endif
        end
      end else begin
        check("idle_data", data_out, 32'h0);
        check("idle_id", 32'(id_out), 32'd0);
`ifdef DMEM_ALIGN_CHK_EN
        check("idle_err", 32'(err_out), 32'd0);
`endif
      end
    end
  end

  initial begin
    logic [3:0] id;
    #2;
    apply_reset();

    // Six back-to-back loads while the sweep runs: four fit, two are dropped.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, rand_addr(), 32'h0, 4'(i));
    wait_init();
    drain();

    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'd3);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'd4);
    drain();

    id = 4'd8;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, id);
      id = id + 4'd1;
    end
    drain();

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        drive(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, id);
        id = id + 4'd1;
      end else begin
        idle(1);
      end
    end
    drain();

    // Reset with two requests in flight; nothing may emerge afterwards.
    drive(1'b1, 1'b1, 32'h20, 32'h12345678, 4'd6);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'd7);
    idle(1);
    apply_reset();
    idle(20);
    wait_init();
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'd9);
    drain();

`ifdef DMEM_ALIGN_CHK_EN
    drive(1'b1, 1'b1, 32'h12, 32'h5, 4'd1);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'd2);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
